zedcam_pixel_capture: RTL and testbench

Camera front end for the ZedCam IP. It samples the OV7670-style parallel bus (PCLK/HREF/VSYNC/D[7:0]) in the ACLK domain and packs RGB565 pixels two per 32-bit word. It emits the words as an AXI4-Stream with frame and line markers, toward the frame-buffer writer. Control and status connect to the ZedCamAXI AXI4-Lite slave register bank: enable and mode come from its control register, counters and sticky errors go to its status registers.

---
 rtl/zedcam_pkg.sv | 24 ++
 rtl/zedcam_out_fifo.sv | 76 +++++++
 rtl/zedcam_pixel_capture.sv | 277 +++++++++++++++++++++++++++
 tb/tb_zedcam_pixel_capture.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zedcam_pkg.sv
// Shared definitions for the ZedCam camera capture front end.
// Contents: capture FSM state encoding, pixel/word geometry and the
// output buffer entry layout {tuser, tlast, tdata}.
package zedcam_pkg;

    localparam int PIX_W          = 16;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int BPW_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_VSYNC = 2'd1,
        ST_CAPTURE    = 2'd2,
        ST_DONE       = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic              tuser;
        logic              tlast;
        logic [WORD_W-1:0] tdata;
    } out_entry_t;

endpackage

// File: rtl/zedcam_out_fifo.sv
// Synchronous output buffer for packed camera words, presented as an
// AXI4-Stream source.
// Ports: clk/rst_n (async active-low), push + push_entry (write side, a
// push while full is accepted only if a pop happens in the same cycle),
// full/empty flags, out_tdata/out_tvalid/out_tready/out_tlast/out_tuser.
module zedcam_out_fifo
    import zedcam_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  out_entry_t        push_entry,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output logic              out_tuser
);

    localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    out_entry_t    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          pop;
    logic          wr_en;
    out_entry_t    head;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign pop   = ~empty & out_tready;
    assign wr_en = push & (~full | pop);
    assign head  = mem_q[rd_ptr_q];

    // The bus reads as zero while empty so no stale entry is ever visible.
    assign out_tvalid = ~empty;
    assign out_tdata  = empty ? '0 : head.tdata;
    assign out_tlast  = ~empty & head.tlast;
    assign out_tuser  = ~empty & head.tuser;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= push_entry;
    end

endmodule

// File: rtl/zedcam_pixel_capture.sv
// ZedCam camera front end: samples an OV7670-style parallel bus in the
// ACLK domain, packs RGB565 pixels two per 32-bit word and streams them
// out with start-of-frame (tuser) and end-of-line (tlast) markers.
// Ports: ACLK/ARESETN (async active-low); cam_pclk/cam_href/cam_vsync/
// cam_data (camera bus, sampled as data); ctrl_enable/ctrl_single/
// ctrl_clear (control register); out_t* (AXI4-Stream master);
// stat_* (frame/line counters, busy, sticky overflow and format errors).
module zedcam_pixel_capture
    import zedcam_pkg::*;
#(
    parameter int MAX_COLS    = 640,
    parameter int MAX_ROWS    = 480,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            cam_pclk,
    input  logic                            cam_href,
    input  logic                            cam_vsync,
    input  logic [7:0]                      cam_data,
    input  logic                            ctrl_enable,
    input  logic                            ctrl_single,
    input  logic                            ctrl_clear,
    output logic [WORD_W-1:0]               out_tdata,
    output logic                            out_tvalid,
    input  logic                            out_tready,
    output logic                            out_tlast,
    output logic                            out_tuser,
    output logic [15:0]                     stat_frame_count,
    output logic [$clog2(MAX_ROWS+1)-1:0]   stat_line_count,
    output logic                            stat_busy,
    output logic                            stat_overflow,
    output logic                            stat_fmt_err
);

    localparam int                LC_W   = $clog2(MAX_ROWS + 1);
    localparam logic [LC_W-1:0]   LC_MAX = LC_W'(MAX_ROWS);
    // Byte-in-line counter; it wraps, and only its low bits select the
    // byte lane and line parity, so long lines are never truncated.
    localparam int                COL_W  = $clog2(2 * MAX_COLS + 1);
    localparam int                SMP_W  = 11;

    // Async-assert, sync-deassert reset release.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_n      = rst_sync_q[1];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_sync_q <= '0;
        else          rst_sync_q <= rst_sync_d;
    end

    // Input synchronisers: pclk, href, vsync and data travel together so
    // a detected pclk edge sees the byte and levels from the same sample.
    logic [SMP_W-1:0] sync_q [SYNC_STAGES];
    logic [SMP_W-1:0] smp;
    logic [2:0]       prev_q;
    logic             smp_pclk, smp_href, smp_vsync;
    logic [7:0]       smp_data;
    logic             pclk_rise, href_fall, vsync_fall, vsync_rise;

    assign smp       = sync_q[SYNC_STAGES-1];
    assign smp_pclk  = smp[10];
    assign smp_href  = smp[9];
    assign smp_vsync = smp[8];
    assign smp_data  = smp[7:0];

    assign pclk_rise  =  smp_pclk  & ~prev_q[2];
    assign href_fall  = ~smp_href  &  prev_q[1];
    assign vsync_rise =  smp_vsync & ~prev_q[0];
    assign vsync_fall = ~smp_vsync &  prev_q[0];

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= {cam_pclk, cam_href, cam_vsync, cam_data};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= {smp_pclk, smp_href, smp_vsync};
        end
    end

    function automatic logic [WORD_W-1:0] form_word(input logic [7:0] b0, input logic [7:0] b1,
                                                    input logic [7:0] b2, input logic [7:0] b3);
        logic [PIX_W-1:0] pix0, pix1;
        pix0 = {b0, b1};
        pix1 = {b2, b3};
        return {pix1, pix0};
    endfunction

    function automatic logic [LC_W-1:0] line_inc(input logic [LC_W-1:0] v);
        return (v == LC_MAX) ? v : v + LC_W'(1);
    endfunction

    cap_state_e       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [23:0]      byte_buf_q, byte_buf_d;
    out_entry_t       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             sof_q, sof_d;
    logic             drop_q, drop_d;
    logic [LC_W-1:0]  line_q, line_d;
    logic [15:0]      frame_q, frame_d;
    logic             ovf_q, ovf_d;
    logic             fmt_q, fmt_d;

    logic             capturing, byte_in;
    logic [BPW_W-1:0] col_pos;
    logic             word_vld, fifo_push, fifo_full, fifo_empty, pop;
    logic             ovf_set, fmt_set;
    out_entry_t       word;

    assign capturing = (state_q == ST_CAPTURE);
    assign byte_in   = pclk_rise & smp_href;
    assign col_pos   = col_q[BPW_W-1:0];
    assign pop       = out_tvalid & out_tready;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        byte_buf_d = byte_buf_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        sof_d      = sof_q;
        drop_d     = drop_q;
        line_d     = line_q;
        frame_d    = frame_q;
        word_vld   = 1'b0;
        word       = '0;
        fmt_set    = 1'b0;
        fifo_push  = 1'b0;
        ovf_set    = 1'b0;

        // A completed word waits in the hold register until either the
        // next byte (it was not last) or href_fall (it gets tlast).
        if (capturing && byte_in) begin
            if (hold_vld_q && col_pos == '0) begin
                word_vld   = 1'b1;
                word       = hold_q;
                hold_vld_d = 1'b0;
            end
            case (col_pos)
                2'd0:    byte_buf_d[7:0]   = smp_data;
                2'd1:    byte_buf_d[15:8]  = smp_data;
                2'd2:    byte_buf_d[23:16] = smp_data;
                default: begin
                    hold_vld_d     = 1'b1;
                    hold_d.tuser   = sof_q;
                    hold_d.tlast   = 1'b0;
                    hold_d.tdata   = form_word(byte_buf_q[7:0], byte_buf_q[15:8],
                                               byte_buf_q[23:16], smp_data);
                    sof_d          = 1'b0;
                end
            endcase
            col_d = col_q + COL_W'(1);
        end

        if (capturing && href_fall) begin
            line_d = line_inc(line_q);
            col_d  = '0;
            if (col_pos != '0) begin
                // Partial word: flush zero-padded; an odd byte count is a format error.
                word_vld    = 1'b1;
                word.tuser  = sof_q;
                word.tlast  = 1'b1;
                word.tdata  = form_word(byte_buf_q[7:0],
                                        (col_pos >= 2'd2) ? byte_buf_q[15:8]  : 8'h00,
                                        (col_pos == 2'd3) ? byte_buf_q[23:16] : 8'h00,
                                        8'h00);
                sof_d       = 1'b0;
                fmt_set     = col_pos[0];
            end else if (hold_vld_q) begin
                word_vld    = 1'b1;
                word        = hold_q;
                word.tlast  = 1'b1;
                hold_vld_d  = 1'b0;
            end
        end

        // Once a word is lost the rest of the frame is discarded.
        if (word_vld && !drop_q) begin
            if (fifo_full && !pop) begin
                ovf_set = 1'b1;
                drop_d  = 1'b1;
            end else begin
                fifo_push = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_enable) state_d = ST_WAIT_VSYNC;
            end
            ST_WAIT_VSYNC: begin
                if (vsync_fall) begin
                    state_d    = ST_CAPTURE;
                    line_d     = '0;
                    sof_d      = 1'b1;
                    drop_d     = 1'b0;
                    col_d      = '0;
                    hold_vld_d = 1'b0;
                end else if (!ctrl_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (vsync_rise) begin
                    frame_d = frame_q + 16'd1;
                    if (ctrl_single)       state_d = ST_DONE;
                    else if (!ctrl_enable) state_d = ST_IDLE;
                    else                   state_d = ST_WAIT_VSYNC;
                end
            end
            default: begin
                if (!ctrl_enable) state_d = ST_IDLE;
            end
        endcase

        ovf_d = (ovf_q & ~ctrl_clear) | ovf_set;
        fmt_d = (fmt_q & ~ctrl_clear) | fmt_set;
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            hold_vld_q <= 1'b0;
            sof_q      <= 1'b0;
            drop_q     <= 1'b0;
            line_q     <= '0;
            frame_q    <= '0;
            ovf_q      <= 1'b0;
            fmt_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            hold_vld_q <= hold_vld_d;
            sof_q      <= sof_d;
            drop_q     <= drop_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
            ovf_q      <= ovf_d;
            fmt_q      <= fmt_d;
        end
    end

    always_ff @(posedge ACLK) begin
        byte_buf_q <= byte_buf_d;
        hold_q     <= hold_d;
    end

    zedcam_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (ACLK),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry (word),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tlast  (out_tlast),
        .out_tuser  (out_tuser)
    );

    assign stat_frame_count = frame_q;
    assign stat_line_count  = line_q;
    assign stat_busy        = (state_q == ST_WAIT_VSYNC) || (state_q == ST_CAPTURE);
    assign stat_overflow    = ovf_q;
    assign stat_fmt_err     = fmt_q;

endmodule

// File: tb/tb_zedcam_pixel_capture.sv
// Self-checking bench for zedcam_pixel_capture: directed and randomized
// camera frames, expected stream built from byte lists per line.
module tb_zedcam_pixel_capture;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;
    logic        cam_pclk = 1'b0, cam_href = 1'b0, cam_vsync = 1'b1;
    logic [7:0]  cam_data = 8'h00;
    logic        ctrl_enable = 1'b0, ctrl_single = 1'b0, ctrl_clear = 1'b0;
    logic [31:0] out_tdata;
    logic        out_tvalid, out_tready = 1'b1, out_tlast, out_tuser;
    logic [15:0] stat_frame_count;
    logic [8:0]  stat_line_count;
    logic        stat_busy, stat_overflow, stat_fmt_err;

    int n_assert = 0;
    int n_fail   = 0;
    int frames   = 0;

    logic [7:0]  fbytes[$];
    int          flen[$];
    logic [33:0] exp_q[$];
    logic [33:0] rx_q[$];

    zedcam_pixel_capture dut (
        .ACLK             (ACLK),
        .ARESETN          (ARESETN),
        .cam_pclk         (cam_pclk),
        .cam_href         (cam_href),
        .cam_vsync        (cam_vsync),
        .cam_data         (cam_data),
        .ctrl_enable      (ctrl_enable),
        .ctrl_single      (ctrl_single),
        .ctrl_clear       (ctrl_clear),
        .out_tdata        (out_tdata),
        .out_tvalid       (out_tvalid),
        .out_tready       (out_tready),
        .out_tlast        (out_tlast),
        .out_tuser        (out_tuser),
        .stat_frame_count (stat_frame_count),
        .stat_line_count  (stat_line_count),
        .stat_busy        (stat_busy),
        .stat_overflow    (stat_overflow),
        .stat_fmt_err     (stat_fmt_err)
    );

    always #5 ACLK = ~ACLK;

    // Stream monitor: a transfer happens on the next rising edge.
    always @(negedge ACLK) begin
        if (ARESETN && out_tvalid && out_tready)
            rx_q.push_back({out_tuser, out_tlast, out_tdata});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic set_ready(input logic v);
        @(posedge ACLK);
        #2;
        out_tready = v;
    endtask

    task automatic pulse_clear();
        @(posedge ACLK);
        #2 ctrl_clear = 1'b1;
        @(posedge ACLK);
        #2 ctrl_clear = 1'b0;
    endtask

    task automatic tick();
        cam_pclk = 1'b0;
        #40;
        cam_pclk = 1'b1;
        #40;
    endtask

    task automatic clear_frame();
        fbytes.delete();
        flen.delete();
    endtask

    // rnd=0: bytes 0x01, 0x02, ...; rnd=1: random bytes
    task automatic add_line(input int n, input bit rnd);
        for (int i = 0; i < n; i++)
            fbytes.push_back(rnd ? 8'($urandom) : 8'(i + 1));
        flen.push_back(n);
    endtask

    // Expected stream: each line in groups of four bytes, missing bytes
    // read as zero, word = {b2,b3,b0,b1}; last word of each line carries
    // tlast, first word of the frame carries tuser.
    task automatic model_frame();
        int  pos = 0;
        bit  first = 1'b1;
        for (int l = 0; l < flen.size(); l++) begin
            int n = flen[l];
            int nw = (n + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                logic [7:0] b [4];
                for (int k = 0; k < 4; k++)
                    b[k] = (w * 4 + k < n) ? fbytes[pos + w * 4 + k] : 8'h00;
                exp_q.push_back({first, (w == nw - 1), b[2], b[3], b[0], b[1]});
                first = 1'b0;
            end
            pos += n;
        end
    endtask

    task automatic run_frame();
        int pos = 0;
        cam_vsync = 1'b1;
        repeat (4) tick();
        cam_vsync = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < flen.size(); l++) begin
            cam_href = 1'b1;
            for (int i = 0; i < flen[l]; i++) begin
                cam_data = fbytes[pos + i];
                tick();
            end
            cam_href = 1'b0;
            cam_data = 8'h00;
            repeat (3) tick();
            pos += flen[l];
        end
        cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic compare_rx(input string tag);
        wait_cyc(20);
        check($sformatf("%s_nwords", tag), 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1 ARESETN = 1'b0;
        #26;
        // Reset state
        check("rst_tvalid", 64'(out_tvalid), 64'(0));
        check("rst_tdata",  64'(out_tdata), 64'(0));
        check("rst_tlast",  64'(out_tlast), 64'(0));
        check("rst_tuser",  64'(out_tuser), 64'(0));
        check("rst_frames", 64'(stat_frame_count), 64'(0));
        check("rst_lines",  64'(stat_line_count), 64'(0));
        check("rst_busy",   64'(stat_busy), 64'(0));
        check("rst_ovf",    64'(stat_overflow), 64'(0));
        check("rst_fmt",    64'(stat_fmt_err), 64'(0));
        ARESETN = 1'b1;
        wait_cyc(5);
        check("idle_busy", 64'(stat_busy), 64'(0));
        ctrl_enable = 1'b1;
        wait_cyc(5);
        check("wait_busy", 64'(stat_busy), 64'(1));

        // Two 8-byte lines
        clear_frame(); add_line(8, 0); add_line(8, 0);
        model_frame(); run_frame(); frames++;
        compare_rx("t1");
        check("t1_frames", 64'(stat_frame_count), 64'(frames));
        check("t1_lines",  64'(stat_line_count), 64'(2));
        check("t1_fmt",    64'(stat_fmt_err), 64'(0));

        // 6-byte line: padded final word
        clear_frame(); add_line(6, 0);
        model_frame(); run_frame(); frames++;
        compare_rx("t2");
        check("t2_fmt", 64'(stat_fmt_err), 64'(0));

        // 5-byte line: lone byte padded, format error
        clear_frame(); add_line(5, 0);
        model_frame(); run_frame(); frames++;
        compare_rx("t3");
        check("t3_fmt_set", 64'(stat_fmt_err), 64'(1));
        pulse_clear();
        check("t3_fmt_clr", 64'(stat_fmt_err), 64'(0));

        // Randomized frames
        for (int f = 0; f < 3; f++) begin
            int  nl = int'($urandom_range(1, 3));
            bit  odd = 1'b0;
            clear_frame();
            for (int l = 0; l < nl; l++) begin
                int n = int'($urandom_range(1, 24));
                add_line(n, 1);
                if (n % 2 == 1) odd = 1'b1;
            end
            model_frame(); run_frame(); frames++;
            compare_rx($sformatf("rnd%0d", f));
            check($sformatf("rnd%0d_lines", f), 64'(stat_line_count), 64'(nl));
            check($sformatf("rnd%0d_fmt", f), 64'(stat_fmt_err), 64'(odd));
            check($sformatf("rnd%0d_frames", f), 64'(stat_frame_count), 64'(frames));
            pulse_clear();
        end

        // Overflow: sink stalled, only the first two words survive
        set_ready(1'b0);
        clear_frame(); add_line(16, 1); add_line(8, 1);
        model_frame();
        while (exp_q.size() > 2) void'(exp_q.pop_back());
        run_frame(); frames++;
        check("t4_ovf_set", 64'(stat_overflow), 64'(1));
        check("t4_no_xfer", 64'(rx_q.size()), 64'(0));
        check("t4_tvalid",  64'(out_tvalid), 64'(1));
        check("t4_lines",   64'(stat_line_count), 64'(2));
        check("t4_frames",  64'(stat_frame_count), 64'(frames));
        set_ready(1'b1);
        compare_rx("t4_drain");
        pulse_clear();
        check("t4_ovf_clr", 64'(stat_overflow), 64'(0));
        clear_frame(); add_line(12, 1);
        model_frame(); run_frame(); frames++;
        compare_rx("t4_next");

        // Single-frame mode
        ctrl_single = 1'b1;
        clear_frame(); add_line(8, 1); add_line(4, 1);
        model_frame(); run_frame(); frames++;
        clear_frame(); add_line(8, 1);
        run_frame();
        run_frame();
        compare_rx("t5");
        check("t5_frames", 64'(stat_frame_count), 64'(frames));
        check("t5_busy",   64'(stat_busy), 64'(0));
        ctrl_enable = 1'b0;
        wait_cyc(4);
        ctrl_enable = 1'b1;
        wait_cyc(4);
        check("t5_restart_busy", 64'(stat_busy), 64'(1));
        clear_frame(); add_line(10, 1);
        model_frame(); run_frame(); frames++;
        compare_rx("t5_restart");
        check("t5_frames2", 64'(stat_frame_count), 64'(frames));
        ctrl_single = 1'b0;
        ctrl_enable = 1'b0;
        wait_cyc(4);
        ctrl_enable = 1'b1;
        wait_cyc(4);

        // Reset in the middle of a line
        set_ready(1'b0);
        cam_vsync = 1'b0;
        repeat (4) tick();
        cam_href = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) begin
                check("t6_pre_tvalid", 64'(out_tvalid), 64'(1));
                ARESETN = 1'b0;
                #1;
                check("t6_tvalid", 64'(out_tvalid), 64'(0));
                check("t6_frames", 64'(stat_frame_count), 64'(0));
                check("t6_lines",  64'(stat_line_count), 64'(0));
                check("t6_busy",   64'(stat_busy), 64'(0));
                #29 ARESETN = 1'b1;
            end
            cam_data = 8'(8'hA0 + i);
            tick();
        end
        cam_href = 1'b0;
        repeat (3) tick();
        cam_vsync = 1'b1;
        repeat (4) tick();
        check("t6_no_restart", 64'(stat_frame_count), 64'(0));
        rx_q.delete();
        set_ready(1'b1);
        frames = 0;
        clear_frame(); add_line(8, 1); add_line(7, 1);
        model_frame(); run_frame(); frames++;
        compare_rx("t6_resume");
        check("t6_frames_after", 64'(stat_frame_count), 64'(frames));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
